mem_wb_pipe_reg: RTL and testbench

//  Clocked, parametrised MEM/WB pipeline register; replaces the combinational pass-through between MEM and WB.

---
 rtl/mem_wb_pipe_reg.sv | 111 +++++++++++
 tb/tb_mem_wb_pipe_reg.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register.
// Carries a valid bit, a control bus and NUM_CH packed data channels through
// STAGES register stages. The pipe holds on stall, inserts a bubble on flush,
// and counts the valid entries that retire from the last stage.
// ctrl bit0 is RegWrite, so the register-file write enable is valid & ctrl[0].
module mem_wb_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int CTRL_W = 4,
    parameter int STAGES = 1,
    parameter int CNT_W  = 32
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Stall,
    input  logic                     Flush,
    input  logic                     inValid,
    input  logic [CTRL_W-1:0]        inCtrl,
    input  logic [NUM_CH*DATA_W-1:0] inData,
    output logic                     outValid,
    output logic [CTRL_W-1:0]        outCtrl,
    output logic [NUM_CH*DATA_W-1:0] outData,
    output logic                     outWriteEn,
    output logic [CNT_W-1:0]         RetireCount
);

    localparam int BUS_W = NUM_CH * DATA_W;

    // Flush forces the pipe to move even when a stall is requested.
    logic adv;
    assign adv = ~Stall | Flush;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic              valid_q, valid_d;
            logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
            logic [BUS_W-1:0]  data_q,  data_d;

            if (gi == 0) begin : g_head
                // Stage 0 next state: bubble on flush, capture input on advance, else hold
                always_comb begin
                    valid_d = valid_q;
                    ctrl_d  = ctrl_q;
                    data_d  = data_q;
                    if (Flush) begin
                        valid_d = 1'b0;
                        ctrl_d  = '0;
                        data_d  = '0;
                    end else if (!Stall) begin
                        valid_d = inValid;
                        ctrl_d  = inCtrl;
                        data_d  = inData;
                    end
                end
            end else begin : g_body
                // Later stages take the previous stage's contents on advance, else hold
                always_comb begin
                    valid_d = valid_q;
                    ctrl_d  = ctrl_q;
                    data_d  = data_q;
                    if (adv) begin
                        valid_d = g_stage[gi-1].valid_q;
                        ctrl_d  = g_stage[gi-1].ctrl_q;
                        data_d  = g_stage[gi-1].data_q;
                    end
                end
            end

            // Stage register; reset empties the stage regardless of stall or flush
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    valid_q <= 1'b0;
                    ctrl_q  <= '0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    ctrl_q  <= ctrl_d;
                    data_q  <= data_d;
                end
            end
        end
    endgenerate

    // Retire counter: an entry retires when the pipe advances past a valid last stage
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // Counter next state; wraps silently at all-ones
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (adv && g_stage[STAGES-1].valid_q) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign outValid    = g_stage[STAGES-1].valid_q;
    assign outCtrl     = g_stage[STAGES-1].ctrl_q;
    assign outData     = g_stage[STAGES-1].data_q;
    assign outWriteEn  = g_stage[STAGES-1].valid_q & g_stage[STAGES-1].ctrl_q[0];
    assign RetireCount = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Testbench for mem_wb_pipe_reg: four instances share one stimulus stream
// (STAGES=1/2/3, NUM_CH=4/1, CNT_W=32/4) and are checked with directed
// scenarios plus a random stream against a queue-based reference.
module tb_mem_wb_pipe_reg;

    logic         clk;
    logic         rst_n;
    logic         stall;
    logic         flush;
    logic         in_valid;
    logic [3:0]   in_ctrl;
    logic [127:0] in_data;

    logic         o1_valid, o2_valid, o3_valid, o4_valid;
    logic [3:0]   o1_ctrl,  o2_ctrl,  o3_ctrl,  o4_ctrl;
    logic [127:0] o1_data,  o2_data,  o3_data;
    logic [31:0]  o4_data;
    logic         o1_we,    o2_we,    o3_we,    o4_we;
    logic [31:0]  o1_cnt,   o2_cnt,   o4_cnt;
    logic [3:0]   o3_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic         v;
        logic [3:0]   c;
        logic [127:0] d;
    } ent_t;

    mem_wb_pipe_reg #(.DATA_W(32), .NUM_CH(4), .CTRL_W(4), .STAGES(1), .CNT_W(32)) u1 (
        .Clk(clk), .Rst_n(rst_n), .Stall(stall), .Flush(flush), .inValid(in_valid),
        .inCtrl(in_ctrl), .inData(in_data), .outValid(o1_valid), .outCtrl(o1_ctrl),
        .outData(o1_data), .outWriteEn(o1_we), .RetireCount(o1_cnt));

    mem_wb_pipe_reg #(.DATA_W(32), .NUM_CH(4), .CTRL_W(4), .STAGES(2), .CNT_W(32)) u2 (
        .Clk(clk), .Rst_n(rst_n), .Stall(stall), .Flush(flush), .inValid(in_valid),
        .inCtrl(in_ctrl), .inData(in_data), .outValid(o2_valid), .outCtrl(o2_ctrl),
        .outData(o2_data), .outWriteEn(o2_we), .RetireCount(o2_cnt));

    mem_wb_pipe_reg #(.DATA_W(32), .NUM_CH(4), .CTRL_W(4), .STAGES(1), .CNT_W(4)) u3 (
        .Clk(clk), .Rst_n(rst_n), .Stall(stall), .Flush(flush), .inValid(in_valid),
        .inCtrl(in_ctrl), .inData(in_data), .outValid(o3_valid), .outCtrl(o3_ctrl),
        .outData(o3_data), .outWriteEn(o3_we), .RetireCount(o3_cnt));

    mem_wb_pipe_reg #(.DATA_W(32), .NUM_CH(1), .CTRL_W(4), .STAGES(3), .CNT_W(32)) u4 (
        .Clk(clk), .Rst_n(rst_n), .Stall(stall), .Flush(flush), .inValid(in_valid),
        .inCtrl(in_ctrl), .inData(in_data[31:0]), .outValid(o4_valid), .outCtrl(o4_ctrl),
        .outData(o4_data), .outWriteEn(o4_we), .RetireCount(o4_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_ctrl  = 4'h0;
        in_data  = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        total++; if ({o1_valid, o1_ctrl, o1_data, o1_we, o1_cnt} !== '0) begin bad++; $display("FAIL reset_u1 got=%h exp=0", {o1_valid, o1_ctrl, o1_data, o1_we, o1_cnt}); end
        total++; if ({o2_valid, o2_ctrl, o2_data, o2_we, o2_cnt} !== '0) begin bad++; $display("FAIL reset_u2 got=%h exp=0", {o2_valid, o2_ctrl, o2_data, o2_we, o2_cnt}); end
        total++; if ({o3_valid, o3_ctrl, o3_data, o3_we, o3_cnt} !== '0) begin bad++; $display("FAIL reset_u3 got=%h exp=0", {o3_valid, o3_ctrl, o3_data, o3_we, o3_cnt}); end
        total++; if ({o4_valid, o4_ctrl, o4_data, o4_we, o4_cnt} !== '0) begin bad++; $display("FAIL reset_u4 got=%h exp=0", {o4_valid, o4_ctrl, o4_data, o4_we, o4_cnt}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("test_reset: done");
    endtask

    task automatic test_pass();
        apply_reset();
        in_valid = 1'b1;
        in_ctrl  = 4'b0001;
        in_data  = {96'h0, 32'hDEADBEEF};
        step();
        total++; if (o1_valid !== 1'b1) begin bad++; $display("FAIL pass_valid got=%b exp=1", o1_valid); end
        total++; if (o1_we !== 1'b1) begin bad++; $display("FAIL pass_we got=%b exp=1", o1_we); end
        total++; if (o1_data[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL pass_ch0 got=%h exp=deadbeef", o1_data[31:0]); end
        total++; if (o1_cnt !== 32'd0) begin bad++; $display("FAIL pass_cnt0 got=%0d exp=0", o1_cnt); end
        clear_inputs();
        step();
        total++; if (o1_cnt !== 32'd1) begin bad++; $display("FAIL pass_cnt1 got=%0d exp=1", o1_cnt); end
        total++; if (o1_valid !== 1'b0) begin bad++; $display("FAIL pass_drain got=%b exp=0", o1_valid); end
        $display("test_pass: done");
    endtask

    task automatic test_invalid_entry();
        apply_reset();
        in_valid = 1'b0;
        in_ctrl  = 4'b0101;
        in_data  = {64'h0, 32'h00001234, 32'h0};
        step();
        total++; if ({o1_valid, o1_we} !== 2'b00) begin bad++; $display("FAIL inval_valid_we got=%b exp=00", {o1_valid, o1_we}); end
        total++; if (o1_ctrl !== 4'b0101) begin bad++; $display("FAIL inval_ctrl got=%b exp=0101", o1_ctrl); end
        total++; if (o1_data[63:32] !== 32'h00001234) begin bad++; $display("FAIL inval_ch1 got=%h exp=00001234", o1_data[63:32]); end
        clear_inputs();
        step();
        total++; if (o1_cnt !== 32'd0) begin bad++; $display("FAIL inval_cnt got=%0d exp=0", o1_cnt); end
        $display("test_invalid_entry: done");
    endtask

    task automatic test_async_reset();
        apply_reset();
        in_valid = 1'b1;
        in_ctrl  = 4'b0001;
        in_data  = {96'h0, 32'h55};
        step();
        in_data  = {96'h0, 32'h66};
        step();
        total++; if ({o1_valid, o1_data[31:0], o1_cnt} !== {1'b1, 32'h66, 32'd1}) begin bad++; $display("FAIL arst_pre got=%h exp=%h", {o1_valid, o1_data[31:0], o1_cnt}, {1'b1, 32'h66, 32'd1}); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if ({o1_valid, o1_ctrl, o1_data, o1_we, o1_cnt} !== '0) begin bad++; $display("FAIL arst_u1 got=%h exp=0", {o1_valid, o1_ctrl, o1_data, o1_we, o1_cnt}); end
        total++; if ({o2_valid, o2_data, o2_cnt} !== '0) begin bad++; $display("FAIL arst_u2 got=%h exp=0", {o2_valid, o2_data, o2_cnt}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_data = {96'h0, 32'h77};
        step();
        total++; if ({o1_valid, o1_data[31:0], o1_cnt} !== {1'b1, 32'h77, 32'd0}) begin bad++; $display("FAIL arst_post got=%h exp=%h", {o1_valid, o1_data[31:0], o1_cnt}, {1'b1, 32'h77, 32'd0}); end
        $display("test_async_reset: done");
    endtask

    task automatic test_stall();
        apply_reset();
        in_valid = 1'b1;
        in_ctrl  = 4'b0001;
        in_data  = {96'h0, 32'h11};
        step();
        in_data  = {96'h0, 32'h22};
        step();
        total++; if ({o2_valid, o2_data[31:0]} !== {1'b1, 32'h11}) begin bad++; $display("FAIL stall_load got=%h exp=%h", {o2_valid, o2_data[31:0]}, {1'b1, 32'h11}); end
        stall   = 1'b1;
        in_data = {96'h0, 32'h33};
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({o2_valid, o2_data[31:0], o2_cnt} !== {1'b1, 32'h11, 32'd0}) begin bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, {o2_valid, o2_data[31:0], o2_cnt}, {1'b1, 32'h11, 32'd0}); end
        end
        clear_inputs();
        step();
        total++; if ({o2_valid, o2_data[31:0], o2_cnt} !== {1'b1, 32'h22, 32'd1}) begin bad++; $display("FAIL stall_release got=%h exp=%h", {o2_valid, o2_data[31:0], o2_cnt}, {1'b1, 32'h22, 32'd1}); end
        $display("test_stall: done");
    endtask

    task automatic test_flush();
        apply_reset();
        in_valid = 1'b1;
        in_ctrl  = 4'b0001;
        in_data  = {96'h0, 32'hAA};
        step();
        flush   = 1'b1;
        in_data = {96'h0, 32'hDEADBEEF};
        step();
        total++; if ({o1_valid, o1_we, o1_ctrl, o1_data} !== '0) begin bad++; $display("FAIL flush_bubble got=%h exp=0", {o1_valid, o1_we, o1_ctrl, o1_data}); end
        total++; if (o1_cnt !== 32'd1) begin bad++; $display("FAIL flush_cnt got=%0d exp=1", o1_cnt); end
        flush   = 1'b0;
        in_data = {96'h0, 32'hBB};
        step();
        total++; if ({o1_valid, o1_data[31:0], o1_cnt} !== {1'b1, 32'hBB, 32'd1}) begin bad++; $display("FAIL flush_reload got=%h exp=%h", {o1_valid, o1_data[31:0], o1_cnt}, {1'b1, 32'hBB, 32'd1}); end
        stall   = 1'b1;
        flush   = 1'b1;
        in_data = {96'h0, 32'hCC};
        step();
        total++; if ({o1_valid, o1_we, o1_ctrl, o1_data} !== '0) begin bad++; $display("FAIL stallflush_bubble got=%h exp=0", {o1_valid, o1_we, o1_ctrl, o1_data}); end
        total++; if (o1_cnt !== 32'd2) begin bad++; $display("FAIL stallflush_cnt got=%0d exp=2", o1_cnt); end
        clear_inputs();
        $display("test_flush: done");
    endtask

    task automatic test_wrap();
        apply_reset();
        in_ctrl = 4'b0001;
        for (int i = 1; i <= 17; i++) begin
            in_valid = 1'b1;
            in_data  = {96'h0, 32'(i)};
            step();
            in_valid = 1'b0;
            step();
            if (i == 15) begin
                total++; if (o3_cnt !== 4'd15) begin bad++; $display("FAIL wrap_15 got=%0d exp=15", o3_cnt); end
            end
            if (i == 16) begin
                total++; if (o3_cnt !== 4'd0) begin bad++; $display("FAIL wrap_16 got=%0d exp=0", o3_cnt); end
            end
        end
        total++; if (o3_cnt !== 4'd1) begin bad++; $display("FAIL wrap_17 got=%0d exp=1", o3_cnt); end
        clear_inputs();
        $display("test_wrap: done");
    endtask

    task automatic test_random();
        ent_t q1[$];
        ent_t q2[$];
        ent_t q4[$];
        ent_t ne;
        ent_t ne4;
        ent_t e;
        logic [31:0] c1 = 0;
        logic [31:0] c2 = 0;
        logic [31:0] c4 = 0;
        apply_reset();
        q1.push_back('0);
        repeat (2) q2.push_back('0);
        repeat (3) q4.push_back('0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            stall    = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 5) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_ctrl  = 4'($urandom_range(0, 15));
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            ne.v = in_valid;
            ne.c = in_ctrl;
            ne.d = in_data;
            if (flush) ne = '0;
            ne4 = ne;
            ne4.d[127:32] = '0;
            if (!stall || flush) begin
                e = q1.pop_front(); if (e.v) c1++; q1.push_back(ne);
                e = q2.pop_front(); if (e.v) c2++; q2.push_back(ne);
                e = q4.pop_front(); if (e.v) c4++; q4.push_back(ne4);
            end
            step();
            total++; if ({o1_valid, o1_ctrl, o1_data, o1_we, o1_cnt} !== {q1[0].v, q1[0].c, q1[0].d, q1[0].v & q1[0].c[0], c1}) begin bad++; $display("FAIL rand_s1 cyc=%0d got=%h exp=%h", cyc, {o1_valid, o1_ctrl, o1_data, o1_we, o1_cnt}, {q1[0].v, q1[0].c, q1[0].d, q1[0].v & q1[0].c[0], c1}); end
            total++; if ({o2_valid, o2_ctrl, o2_data, o2_we, o2_cnt} !== {q2[0].v, q2[0].c, q2[0].d, q2[0].v & q2[0].c[0], c2}) begin bad++; $display("FAIL rand_s2 cyc=%0d got=%h exp=%h", cyc, {o2_valid, o2_ctrl, o2_data, o2_we, o2_cnt}, {q2[0].v, q2[0].c, q2[0].d, q2[0].v & q2[0].c[0], c2}); end
            total++; if ({o4_valid, o4_ctrl, o4_data, o4_we, o4_cnt} !== {q4[0].v, q4[0].c, q4[0].d[31:0], q4[0].v & q4[0].c[0], c4}) begin bad++; $display("FAIL rand_s3 cyc=%0d got=%h exp=%h", cyc, {o4_valid, o4_ctrl, o4_data, o4_we, o4_cnt}, {q4[0].v, q4[0].c, q4[0].d[31:0], q4[0].v & q4[0].c[0], c4}); end
        end
        clear_inputs();
        $display("test_random: done, retired s1=%0d s2=%0d s3=%0d", c1, c2, c4);
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #1;
        test_reset();
        test_pass();
        test_invalid_entry();
        test_async_reset();
        test_stall();
        test_flush();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
